// File: rtl/cdc_fifo_pkg.sv
// Shared types for the CDC FIFO write-side arbiter: FSM state encoding and
// the width of the per-burst beat counter.
package cdc_fifo_pkg;

  localparam int BEAT_COUNT_WIDTH = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin search: first set bit of valid_i scanning upward,
// with wrap, starting just above last_grant_i.
module round_robin_picker #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = 2
) (
  input  logic [NUM_REQUESTERS-1:0] valid_i,
  input  logic [ID_WIDTH-1:0]       last_grant_i,
  output logic                      found_o,
  output logic [ID_WIDTH-1:0]       index_o
);

  // Scan from the farthest candidate down to the nearest so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int k = NUM_REQUESTERS; k >= 1; k--) begin
      int cand;
      cand    = (int'(last_grant_i) + k) % NUM_REQUESTERS;
      found_o = found_o | valid_i[cand];
      index_o = valid_i[cand] ? ID_WIDTH'(cand) : index_o;
    end
  end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin burst arbiter feeding the write side of a CDC FIFO; each granted
// requester streams up to MAX_BURST beats tagged with its ID.
module cdc_fifo_write_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 8,
  localparam int ID_WIDTH      = ($clog2(NUM_REQUESTERS) > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [NUM_REQUESTERS-1:0]            req_last,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  input  logic                                 fifo_full,
  output logic                                 fifo_increment,
  output logic [ID_WIDTH+DATA_WIDTH-1:0]       fifo_write_data,
  output logic                                 grant_active,
  output logic [ID_WIDTH-1:0]                  grant_id
);

  localparam logic [BEAT_COUNT_WIDTH-1:0] MAX_BURST_C = BEAT_COUNT_WIDTH'(MAX_BURST);
  localparam logic [BEAT_COUNT_WIDTH-1:0] BEAT_ONE    = {{(BEAT_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ID_WIDTH-1:0]         LAST_RESET  = ID_WIDTH'(NUM_REQUESTERS - 1);

  arb_state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]         grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]         last_grant_q, last_grant_d;
  logic [BEAT_COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [BEAT_COUNT_WIDTH-1:0] beat_inc_s;
  logic                        found_s;
  logic [ID_WIDTH-1:0]         pick_s;
  logic                        in_burst_s;
  logic                        beat_s;
  logic                        burst_end_s;

  round_robin_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .ID_WIDTH      (ID_WIDTH)
  ) u_picker (
    .valid_i     (req_valid),
    .last_grant_i(last_grant_q),
    .found_o     (found_s),
    .index_o     (pick_s)
  );

  assign in_burst_s  = (state_q == ARB_BURST);
  assign beat_s      = in_burst_s & req_valid[grant_id_q] & ~fifo_full;
  assign beat_inc_s  = beat_count_q + BEAT_ONE;
  assign burst_end_s = req_last[grant_id_q] | (beat_inc_s == MAX_BURST_C);

  // Next-state: grant from IDLE, count beats and release at last/limit in BURST.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_count_d = beat_count_q;
    case (state_q)
      ARB_IDLE: begin
        if (found_s) begin
          state_d      = ARB_BURST;
          grant_id_d   = pick_s;
          beat_count_d = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        if (beat_s) begin
          beat_count_d = beat_inc_s;
          if (burst_end_s) begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_id_q;
          end else begin
            state_d = ARB_BURST;
          end
        end else begin
          state_d = ARB_BURST;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; last_grant resets to the top requester so requester 0 goes first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RESET;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_count_q <= beat_count_d;
    end
  end

  // Only the granted requester sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_q] = in_burst_s & ~fifo_full;
  end

  assign fifo_increment  = beat_s;
  assign fifo_write_data = {grant_id_q, req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH]};
  assign grant_active    = in_burst_s;
  assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level behavioural model of the round-robin burst arbiter.
module tb_cdc_fifo_write_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 8;
  localparam int IDW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [N*DW-1:0]   req_data;
  logic              fifo_full, fifo_increment;
  logic [IDW+DW-1:0] fifo_write_data;
  logic              grant_active;
  logic [IDW-1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit m_busy;
  int m_gid, m_last, m_beats;
  logic [N-1:0]      e_ready;
  logic              e_inc;
  logic [IDW+DW-1:0] e_wdata;
  logic              e_active;
  logic [IDW-1:0]    e_gid;

  // observed grants (rising grant_active) and writes
  int                grants_q[$];
  logic [IDW+DW-1:0] writes_q[$];
  logic              act_prev = 1'b0;

  always #5 clock = ~clock;

  cdc_fifo_write_arbiter #(
    .NUM_REQUESTERS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_increment(fifo_increment),
    .fifo_write_data(fifo_write_data), .grant_active(grant_active), .grant_id(grant_id)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (grant_active && !act_prev) grants_q.push_back(int'(grant_id));
      if (fifo_increment) writes_q.push_back(fifo_write_data);
    end
    act_prev <= grant_active;
  end

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  function void model_reset();
    m_busy = 0; m_gid = 0; m_last = N - 1; m_beats = 0;
  endfunction

  function void model_comb();
    e_ready  = '0;
    e_inc    = 1'b0;
    e_active = m_busy;
    e_gid    = IDW'(m_gid);
    e_wdata  = {e_gid, req_data[m_gid*DW +: DW]};
    if (m_busy && !fifo_full) begin
      e_ready[m_gid] = 1'b1;
      e_inc          = req_valid[m_gid];
    end
  endfunction

  function void model_edge();
    bit got;
    got = 0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (!got && req_valid[(m_last + k) % N]) begin
          got = 1; m_gid = (m_last + k) % N; m_busy = 1; m_beats = 0;
        end
      end
    end else if (req_valid[m_gid] && !fifo_full) begin
      m_beats++;
      if (req_last[m_gid] || m_beats == MB) begin
        m_busy = 0; m_last = m_gid;
      end
    end
  endfunction

  task automatic advance();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = rand_data();
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    grants_q.delete(); writes_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_last = '0; fifo_full = 1'b0; req_data = rand_data();
    @(posedge clock); #1;
    checks++;
    if ({req_ready, fifo_increment, grant_active, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b inc=%b act=%b gid=%0d want all zero",
               req_ready, fifo_increment, grant_active, grant_id);
    end
    do_reset();
  endtask

  task automatic test_alternating();
    int exp_g[3] = '{0, 2, 0};
    bit ok;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = 4'b0101; req_last = 4'b1111; fifo_full = 1'b0; req_data = rand_data();
      @(negedge clock); model_comb();
      checks++;
      if ({req_ready, fifo_increment, fifo_write_data, grant_active, grant_id} !==
          {e_ready, e_inc, e_wdata, e_active, e_gid}) begin
        errors++;
        $display("FAIL alt_cycle c=%0d got %h want %h", c,
                 {req_ready, fifo_increment, fifo_write_data, grant_active, grant_id},
                 {e_ready, e_inc, e_wdata, e_active, e_gid});
      end
      advance();
    end
    ok = (grants_q.size() == 3) && (writes_q.size() == 3);
    for (int i = 0; i < 3 && i < grants_q.size() && i < writes_q.size(); i++)
      if (grants_q[i] != exp_g[i] || int'(writes_q[i][DW +: IDW]) != exp_g[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL alt_sequence got %0d grants %0d writes want grants/ids 0,2,0",
               grants_q.size(), writes_q.size());
    end
  endtask

  task automatic test_max_burst();
    int sent = 0;
    int exp_g[5] = '{1, 3, 1, 3, 1};
    int exp_ids[$];
    bit ok;
    do_reset();
    for (int c = 0; c < 34; c++) begin
      req_valid = {1'b1, 1'b0, (sent < 20), 1'b0};
      req_last  = 4'b1000; fifo_full = 1'b0; req_data = rand_data();
      @(negedge clock); model_comb();
      checks++;
      if ({req_ready, fifo_increment, fifo_write_data, grant_active, grant_id} !==
          {e_ready, e_inc, e_wdata, e_active, e_gid}) begin
        errors++;
        $display("FAIL maxburst_cycle c=%0d got %h want %h", c,
                 {req_ready, fifo_increment, fifo_write_data, grant_active, grant_id},
                 {e_ready, e_inc, e_wdata, e_active, e_gid});
      end
      if (e_inc && m_gid == 1) sent++;
      advance();
    end
    for (int i = 0; i < 8; i++) exp_ids.push_back(1);
    exp_ids.push_back(3);
    for (int i = 0; i < 8; i++) exp_ids.push_back(1);
    exp_ids.push_back(3);
    for (int i = 0; i < 4; i++) exp_ids.push_back(1);
    ok = (grants_q.size() == 5);
    for (int i = 0; i < 5 && i < grants_q.size(); i++) if (grants_q[i] != exp_g[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL maxburst_grants got %0d grants want 1,3,1,3,1", grants_q.size());
    end
    ok = (writes_q.size() == exp_ids.size());
    for (int i = 0; i < exp_ids.size() && i < writes_q.size(); i++)
      if (int'(writes_q[i][DW +: IDW]) != exp_ids[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL maxburst_writes got %0d writes want %0d (8x1,3,8x1,3,4x1)",
               writes_q.size(), exp_ids.size());
    end
  endtask

  task automatic test_full_stall();
    int acc = 0;
    int bad = 0;
    int stall_cycles = 0;
    bit ok;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      req_valid = (c < 14) ? 4'b0001 : 4'b0000;
      req_last  = 4'b0000;
      fifo_full = (c >= 4 && c < 9);
      req_data  = rand_data();
      req_data[7:0] = 8'(8'hA0 + acc);
      @(negedge clock); model_comb();
      checks++;
      if ({req_ready, fifo_increment, fifo_write_data, grant_active, grant_id} !==
          {e_ready, e_inc, e_wdata, e_active, e_gid}) begin
        errors++;
        $display("FAIL stall_cycle c=%0d got %h want %h", c,
                 {req_ready, fifo_increment, fifo_write_data, grant_active, grant_id},
                 {e_ready, e_inc, e_wdata, e_active, e_gid});
      end
      if (fifo_full && grant_active) stall_cycles++;
      if (fifo_full && (fifo_increment || req_ready != '0)) bad++;
      if (e_inc) acc++;
      advance();
    end
    checks++;
    if (bad != 0 || stall_cycles != 5) begin
      errors++;
      $display("FAIL stall_window got %0d stalled cycles %0d writes-under-full want 5 and 0",
               stall_cycles, bad);
    end
    ok = (writes_q.size() == 8) && (grants_q.size() == 1);
    for (int i = 0; i < 8 && i < writes_q.size(); i++)
      if (writes_q[i] !== {2'd0, 8'(8'hA0 + i)}) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_data got %0d writes %0d grants want 8 writes A0..A7 in 1 grant",
               writes_q.size(), grants_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'b0001; req_last = 4'b0000; fifo_full = 1'b0; req_data = rand_data();
      @(negedge clock); model_comb();
      checks++;
      if ({req_ready, fifo_increment, grant_active, grant_id} !==
          {e_ready, e_inc, e_active, e_gid}) begin
        errors++;
        $display("FAIL rstmid_pre c=%0d got %h want %h", c,
                 {req_ready, fifo_increment, grant_active, grant_id},
                 {e_ready, e_inc, e_active, e_gid});
      end
      if (c < 3) advance();
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, fifo_increment, grant_active, grant_id} !== '0) begin
      errors++;
      $display("FAIL rstmid_async got ready=%b inc=%b act=%b gid=%0d want all zero",
               req_ready, fifo_increment, grant_active, grant_id);
    end
    @(posedge clock); #1;
    reset = 1'b0; model_reset(); req_valid = 4'b1000;
    @(negedge clock); model_comb();
    checks++;
    if ({req_ready, fifo_increment, grant_active, grant_id} !==
        {e_ready, e_inc, e_active, e_gid}) begin
      errors++;
      $display("FAIL rstmid_idle got %h want %h",
               {req_ready, fifo_increment, grant_active, grant_id},
               {e_ready, e_inc, e_active, e_gid});
    end
    advance();
    @(negedge clock);
    checks++;
    if (grant_id !== 2'd3 || grant_active !== 1'b1 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_regrant got gid=%0d act=%b ready=%b want gid=3 act=1 ready=1000",
               grant_id, grant_active, req_ready);
    end
    advance();
  endtask

  task automatic test_valid_drop();
    int hold = 0;
    int exp_ids[5] = '{0, 0, 0, 0, 1};
    bit ok;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      req_valid = (c >= 3 && c <= 6) ? 4'b0110 : 4'b0111;
      req_last  = {2'b01, 1'b1, (c == 8)};
      fifo_full = 1'b0; req_data = rand_data();
      @(negedge clock); model_comb();
      checks++;
      if ({req_ready, fifo_increment, fifo_write_data, grant_active, grant_id} !==
          {e_ready, e_inc, e_wdata, e_active, e_gid}) begin
        errors++;
        $display("FAIL drop_cycle c=%0d got %h want %h", c,
                 {req_ready, fifo_increment, fifo_write_data, grant_active, grant_id},
                 {e_ready, e_inc, e_wdata, e_active, e_gid});
      end
      if (c >= 3 && c <= 6 && grant_active && grant_id == 2'd0 && !fifo_increment) hold++;
      advance();
    end
    ok = (hold == 4) && (writes_q.size() == 5) && (grants_q.size() == 2);
    for (int i = 0; i < 5 && i < writes_q.size(); i++)
      if (int'(writes_q[i][DW +: IDW]) != exp_ids[i]) ok = 0;
    if (grants_q.size() == 2 && (grants_q[0] != 0 || grants_q[1] != 1)) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drop_hold got hold=%0d writes=%0d grants=%0d want 4, 5 (0,0,0,0,1), 2 (0,1)",
               hold, writes_q.size(), grants_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom & $urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      req_data  = rand_data();
      @(negedge clock); model_comb();
      checks++;
      if ({req_ready, fifo_increment, fifo_write_data, grant_active, grant_id} !==
          {e_ready, e_inc, e_wdata, e_active, e_gid}) begin
        errors++;
        $display("FAIL random_cycle c=%0d got %h want %h", c,
                 {req_ready, fifo_increment, fifo_write_data, grant_active, grant_id},
                 {e_ready, e_inc, e_wdata, e_active, e_gid});
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_max_burst();
    test_full_stall();
    test_reset_mid_burst();
    test_valid_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_write_arbiter.md
CDC_FIFO_WRITE_ARBITER -- requirements
Module: cdc_fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQUESTERS, default 4, giving the number of requester ports (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per requester.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, giving the maximum beats per grant (1..255).
REQ-004 The block SHALL derive ID_WIDTH = max(1, $clog2(NUM_REQUESTERS)) as a localparam.
REQ-005 The block SHALL have port clock, input, 1 bit: the write-domain clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, NUM_REQUESTERS bits: per-requester beat valid.
REQ-008 The block SHALL have port req_last, input, NUM_REQUESTERS bits: per-requester end-of-burst marker, qualified by req_valid.
REQ-009 The block SHALL have port req_data, input, NUM_REQUESTERS*DATA_WIDTH bits: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port req_ready, output, NUM_REQUESTERS bits: per-requester beat accept.
REQ-011 The block SHALL have port fifo_full, input, 1 bit: the full flag of the FIFO write state.
REQ-012 The block SHALL have port fifo_increment, output, 1 bit: the FIFO write strobe.
REQ-013 The block SHALL have port fifo_write_data, output, ID_WIDTH+DATA_WIDTH bits: {grant_id, payload}.
REQ-014 The block SHALL have port grant_active, output, 1 bit: high while in BURST.
REQ-015 The block SHALL have port grant_id, output, ID_WIDTH bits: the current or most recent granted requester.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-017 In IDLE with any req_valid set, the FSM SHALL register a grant to the first valid requester searching upward, with wrap, from last_grant+1, and enter BURST on the next edge; arbitration latency is 1 cycle.
REQ-018 In IDLE, req_ready SHALL be all-zero and fifo_increment SHALL be 0.
REQ-019 In BURST, req_ready[grant_id] SHALL equal !fifo_full, and all other req_ready bits SHALL be 0.
REQ-020 In BURST, fifo_increment SHALL equal req_valid[grant_id] & !fifo_full, combinationally with no register stage.
REQ-021 fifo_write_data SHALL equal {grant_id, req_data slice of grant_id} at all times.
REQ-022 A beat SHALL be defined as fifo_increment high at a rising clock edge; the 8-bit beat_count SHALL increment per beat and clear on entering BURST.
REQ-023 BURST SHALL exit to IDLE on the edge of a beat with req_last[grant_id]=1, or on the beat where beat_count+1 == MAX_BURST; last_grant SHALL update to grant_id on that edge.
REQ-024 Deassertion of req_valid[grant_id] mid-burst SHALL hold the grant with no write and no timeout.
REQ-025 Under fifo_full in BURST, the block SHALL accept no beat, SHALL not drop data, and SHALL not advance beat_count.
REQ-026 Requests arriving during BURST SHALL not preempt the current grant.
REQ-027 After exit from BURST, at least one IDLE cycle SHALL occur before the next grant; the arbitration is round-robin with no starvation.

Reset
REQ-028 While reset is high, the block SHALL force the FSM to IDLE, beat_count=0, grant_id=0, last_grant=NUM_REQUESTERS-1, req_ready=0, fifo_increment=0, and grant_active=0, immediately and including mid-burst.
REQ-029 After reset release, requester 0 SHALL have first priority.

Structure
REQ-030 Package cdc_fifo_pkg SHALL hold typedef enum arb_state_t {ARB_IDLE, ARB_BURST} and the beat-count width constant.
REQ-031 The design SHALL contain one sub-module, round_robin_picker, which is combinational: it takes (valid vector, last_grant) and returns (found, index).

Verification
REQ-032 Scenario: req_valid=4'b0101, all req_last=1, fifo_full=0, after reset -> grants go 0, then 2, then 0, each single-beat with one IDLE cycle between, and fifo_write_data tagged with ID 0/2.
REQ-033 Scenario: requester 1 streams 20 beats with req_last never set, MAX_BURST=8 -> grants release after beats 8 and 16; requester 3, valid throughout, is granted between those bursts.
REQ-034 Scenario: fifo_full held high for 5 cycles mid-burst -> req_ready=0 and fifo_increment=0 for 5 cycles, with no beat lost and beat_count frozen.
REQ-035 Scenario: reset asserted at beat 3 of a burst -> outputs are zero in the same cycle; after release with req_valid=4'b1000, grant_id=3 after 1 cycle.
REQ-036 Scenario: granted requester drops req_valid for 4 cycles while others request -> grant is held, there are 0 writes, and the burst resumes and completes on req_last.
